// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Divide support is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int MD_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Bits needed to hold a count of 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for
// divide (divide path present only with MULDIV_DIV_EN).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_DEFAULT_WIDTH
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] low;
    logic [WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   trial;
`endif

    always_comb begin
        up  = acc[2*WIDTH-1:WIDTH];
        low = acc[WIDTH-1:0];
        // Multiply: the multiplier sits in the low half and is consumed LSB first.
        sum      = {1'b0, up} + (low[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        acc_next = {sum, low[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Divide: {rem, quotient/dividend}; a borrow in the top bit means restore.
        trial = {up, low[WIDTH-1]} - {1'b0, opnd};
        if (div) begin
            if (trial[WIDTH])
                acc_next = {up[WIDTH-2:0], low[WIDTH-1], low[WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH-1:0], low[WIDTH-2:0], 1'b1};
        end
`else
        if (div) acc_next = acc;
`endif
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers, abort and
// mthi/mtlo. Divide datapath is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = clog2(WIDTH);

    md_state_e          state, state_nx;
    md_op_e             op_e;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   opnd, ma, mb, res_hi, res_lo;
    logic               is_div, neg_hi, neg_lo;
    logic               op_signed, op_div, sa, sb, launch, fix_wr, mt_ok;

    assign op_e = md_op_e'(op);

    always_comb begin
        op_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
        op_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
        sa        = op_signed & a[WIDTH-1];
        sb        = op_signed & b[WIDTH-1];
        ma        = sa ? -a : a;
        mb        = sb ? -b : b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != MD_IDLE);
        done     = 1'b0;
        fix_wr   = 1'b0;
        launch   = 1'b0;
        mt_ok    = 1'b0;
        case (state)
            MD_IDLE: begin
                launch = start && !abort;
                mt_ok  = !start;
                if (launch) begin
`ifdef MULDIV_DIV_EN
                    state_nx = (op_div && (b == '0)) ? MD_FIX : MD_RUN;
`else
                    state_nx = op_div ? MD_FIX : MD_RUN;
`endif
                end
            end
            MD_RUN: begin
                if (abort)         state_nx = MD_IDLE;
                else if (cnt == '0) state_nx = MD_FIX;
            end
            MD_FIX: begin
                state_nx = MD_IDLE;
                if (!abort) begin
                    done   = 1'b1;
                    fix_wr = 1'b1;
                end
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div      (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    // Sign correction: product negates as a whole, quotient/remainder separately.
    always_comb begin
        prod = neg_lo ? -acc : acc;
        if (is_div) begin
            res_hi = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
        end else begin
            if (launch) begin
                is_div <= op_div;
                cnt    <= CW'(WIDTH - 1);
                neg_lo <= sa ^ sb;
                neg_hi <= op_div ? sa : (sa ^ sb);
                if (op_div) begin
                    opnd <= mb;
                    acc  <= {{WIDTH{1'b0}}, ma};
`ifdef MULDIV_DIV_EN
                    // Divide by zero skips RUN; preload the fixed result unsigned.
                    if (b == '0) begin
                        acc    <= {a, {WIDTH{1'b1}}};
                        neg_lo <= 1'b0;
                        neg_hi <= 1'b0;
                    end
`endif
                end else begin
                    opnd <= ma;
                    acc  <= {{WIDTH{1'b0}}, mb};
                end
            end else if (state == MD_RUN) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
`ifdef MULDIV_DIV_EN
            if (fix_wr) begin
`else
            if (fix_wr && !is_div) begin
`endif
                hi <= res_hi;
                lo <= res_lo;
            end else if (mt_ok) begin
                if (we_hi) hi <= wd;
                if (we_lo) lo <= wd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wd = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch at a negedge, accepted at the next posedge (T0); done is seen on
    // the negedge before the edge that writes HI/LO, i.e. latency counts edges.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int exp_lat,
                          input logic [31:0] eh, input logic [31:0] el);
        int n, bc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; bc = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            if (busy) bc++;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (busy) bc++;
        chk({tag, " latency"}, 64'(n + 1), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(bc), 64'(exp_lat));
        @(negedge clk);
        chk({tag, " busy after"}, {63'd0, busy}, 64'd0);
        chk({tag, " done after"}, {63'd0, done}, 64'd0);
        chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        int seen;
        #12;
        chk("reset hi", {32'd0, hi}, 64'd0);
        chk("reset lo", {32'd0, lo}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        @(negedge clk); rst = 1'b1;

        run_op("mult -3*5", 2'd0, 32'hFFFFFFFD, 32'd5, 33, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult 7*-6", 2'd0, 32'd7, 32'hFFFFFFFA, 33, 32'hFFFFFFFF, 32'hFFFFFFD6);
        run_op("mult min*min", 2'd0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run_op("multu max*max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h1);

`ifdef MULDIV_DIV_EN
        run_op("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div 7/-2", 2'd2, 32'd7, 32'hFFFFFFFE, 33, 32'h1, 32'hFFFFFFFD);
        run_op("div min/-1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu 10/0", 2'd3, 32'd10, 32'd0, 1, 32'h0000000A, 32'hFFFFFFFF);
        run_op("div -5/0", 2'd2, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);
`else
        run_op("divu 10/0 nodiv", 2'd3, 32'd10, 32'd0, 1, 32'hFFFFFFFE, 32'h1);
        run_op("div 9/3 nodiv", 2'd2, 32'd9, 32'd3, 1, 32'hFFFFFFFE, 32'h1);
`endif

        // mthi / mtlo in IDLE
        @(negedge clk); we_hi = 1'b1; wd = 32'h1234;
        @(negedge clk); we_hi = 1'b0; we_lo = 1'b1; wd = 32'h5678;
        @(negedge clk); we_lo = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h1234);
        chk("mtlo", {32'd0, lo}, 64'h5678);

        // abort at cycle 10 of a MULT
        start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) seen++;
        end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort busy", {63'd0, busy}, 64'd0);
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort no done", 64'(seen), 64'd0);
        chk("abort hi", {32'd0, hi}, 64'h1234);
        chk("abort lo", {32'd0, lo}, 64'h5678);

        // start with abort in IDLE launches nothing
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start+abort busy", {63'd0, busy}, 64'd0);

        // start + we_lo same cycle: write dropped; we_hi while busy ignored
        start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3; we_lo = 1'b1; wd = 32'hDEAD;
        @(posedge clk); #1 start = 1'b0; we_lo = 1'b0;
        @(negedge clk);
        chk("start+mtlo lo", {32'd0, lo}, 64'h5678);
        we_hi = 1'b1; wd = 32'hFFFF;
        @(posedge clk); #1 we_hi = 1'b0;
        @(negedge clk);
        chk("mthi busy hi", {32'd0, hi}, 64'h1234);
        seen = 0;
        while (!done && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        chk("multu 2*3 hi", {32'd0, hi}, 64'h0);
        chk("multu 2*3 lo", {32'd0, lo}, 64'h6);

        // back-to-back: launch in the first IDLE cycle after done
        run_op("b2b multu 5*5", 2'd1, 32'd5, 32'd5, 33, 32'h0, 32'd25);
        run_op("b2b mult -1*-1", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0, 32'd1);

        // reset mid-RUN
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst hi", {32'd0, hi}, 64'h0);
        chk("rst lo", {32'd0, lo}, 64'h0);
        @(negedge clk); rst = 1'b1;
        run_op("after rst multu 3*4", 2'd1, 32'd3, 32'd4, 33, 32'h0, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
